// File: rtl/round_robin_granter.sv
// round_robin_granter: registered one-hot round-robin grant held until acknowledged,
// with the priority pointer advancing past the granted requester only on acknowledge.
module round_robin_granter #(
   parameter int C_WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [C_WIDTH-1:0] request,
   input  logic               grant_ack,
   output logic               grant_valid,
   output logic [C_WIDTH-1:0] grant
);
   localparam int PW = (C_WIDTH > 1) ? $clog2(C_WIDTH) : 1;
   typedef enum logic {IDLE, GRANTED} state_t;
   state_t state, state_d;
   logic [PW-1:0] ptr, ptr_d, idx, idx_d, ptr_ack, base, win;
   logic [C_WIDTH-1:0] grant_d;
   logic found, load;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         ptr   <= '0;
         idx   <= '0;
         grant <= '0;
      end else begin
         state <= state_d;
         ptr   <= ptr_d;
         idx   <= idx_d;
         grant <= grant_d;
      end
   always_comb begin
      ptr_ack = (idx == PW'(C_WIDTH - 1)) ? '0 : idx + 1'b1;
      load    = (state == IDLE) || grant_ack;
      base    = (state == GRANTED) ? ptr_ack : ptr;
      found   = 1'b0;
      win     = '0;
      // upper pass covers base..top, lower pass supplies the wrapped-around winner
      for (int k = 0; k < C_WIDTH; k++)
         if (!found && request[k] && PW'(k) >= base) begin
            found = 1'b1;
            win   = PW'(k);
         end
      for (int k = 0; k < C_WIDTH; k++)
         if (!found && request[k]) begin
            found = 1'b1;
            win   = PW'(k);
         end
      state_d = load ? (found ? GRANTED : IDLE) : state;
      ptr_d   = (state == GRANTED && grant_ack) ? ptr_ack : ptr;
      idx_d   = load ? win : idx;
      grant_d = load ? (found ? (C_WIDTH'(1) << win) : '0) : grant;
   end
   assign grant_valid = (state == GRANTED);
endmodule

// File: tb/tb_round_robin_granter.sv
// tb_round_robin_granter: directed scenarios plus randomized traffic checked against
// an index/modulo reference model of the round-robin rules.
module tb_round_robin_granter;
   localparam int W = 4;
   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] request;
   logic         grant_ack;
   logic         grant_valid;
   logic [W-1:0] grant;
   int checks = 0;
   int failures = 0;
   int m_ptr = 0;
   int m_idx = 0;
   bit m_valid = 1'b0;

   round_robin_granter #(.C_WIDTH(W)) dut (
      .clk(clk), .rst(rst), .request(request), .grant_ack(grant_ack),
      .grant_valid(grant_valid), .grant(grant)
   );

   always #5 clk = ~clk;

   function automatic int arb(int b, logic [W-1:0] r);
      for (int d = 0; d < W; d++)
         if (((r >> ((b + d) % W)) & 1) != 0) return (b + d) % W;
      return -1;
   endfunction

   always @(posedge clk or negedge rst)
      if (!rst) begin
         m_valid <= 1'b0;
         m_idx   <= 0;
         m_ptr   <= 0;
      end else if (!m_valid || grant_ack) begin : model_step
         int b, w;
         b = m_valid ? (m_idx + 1) % W : m_ptr;
         w = arb(b, request);
         if (m_valid) m_ptr <= b;
         m_valid <= (w >= 0);
         m_idx   <= (w >= 0) ? w : 0;
      end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cmp_model(input string tag);
      logic [W-1:0] eg;
      eg = m_valid ? (W'(1) << m_idx) : '0;
      chk({tag, "_grant"}, 64'(grant), 64'(eg));
      chk({tag, "_valid"}, 64'(grant_valid), 64'(m_valid));
      chk({tag, "_onehot0"}, 64'($onehot0(grant)), 64'd1);
   endtask

   task automatic expect_out(input string tag, input logic [W-1:0] g, input logic v);
      cmp_model(tag);
      chk({tag, "_grant_exp"}, 64'(grant), 64'(g));
      chk({tag, "_valid_exp"}, 64'(grant_valid), 64'(v));
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0;
      request = 4'b1111;
      grant_ack = 1'b0;
      tick();
      expect_out("reset_hold0", 4'b0000, 1'b0);
      tick();
      expect_out("reset_hold1", 4'b0000, 1'b0);
      rst = 1'b1;
      tick();
      expect_out("reset_first", 4'b0001, 1'b1);
      grant_ack = 1'b1;
      tick(); expect_out("rot1", 4'b0010, 1'b1);
      tick(); expect_out("rot2", 4'b0100, 1'b1);
      tick(); expect_out("rot3", 4'b1000, 1'b1);
      tick(); expect_out("rot4", 4'b0001, 1'b1);
      tick(); expect_out("rot5", 4'b0010, 1'b1);
      tick(); expect_out("rot6", 4'b0100, 1'b1);
      grant_ack = 1'b0;
      request = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         tick();
         expect_out("hold", 4'b0100, 1'b1);
      end
      grant_ack = 1'b1;
      request = 4'b0011;
      tick(); expect_out("wrap", 4'b0001, 1'b1);
      request = 4'b0000;
      tick(); expect_out("drain", 4'b0000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_out("spurious_ack", 4'b0000, 1'b0);
      end
      grant_ack = 1'b0;
      request = 4'b0011;
      tick(); expect_out("after_spurious", 4'b0010, 1'b1);
      #2 rst = 1'b0;
      #1 expect_out("rst_mid", 4'b0000, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      request = 4'b1010;
      tick(); expect_out("rst_release", 4'b0010, 1'b1);
      for (int i = 0; i < 400; i++) begin
         request = ($urandom_range(0, 3) == 0) ? 4'b0000 : W'($urandom);
         grant_ack = 1'($urandom_range(0, 1));
         tick();
         cmp_model("rnd");
         if ($urandom_range(0, 40) == 0) begin
            #2 rst = 1'b0;
            #1 expect_out("rnd_rst", 4'b0000, 1'b0);
            @(negedge clk);
            rst = 1'b1;
         end
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/round_robin_granter.md
ROUND_ROBIN_GRANTER -- requirements
Module: round_robin_granter

Interface
REQ-001 SHALL have parameter C_WIDTH, default 4, meaning the number of requesters (legal range 1 to 64).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, asynchronous active-low reset: assertion clears state immediately, independent of clk.
REQ-004 SHALL have port request, input, C_WIDTH bits, one request line per requester, any combination legal.
REQ-005 SHALL have port grant_ack, input, 1 bit, consumer accepts the current grant this cycle.
REQ-006 SHALL have port grant_valid, output, 1 bit, a grant is presented.
REQ-007 SHALL have port grant, output, C_WIDTH bits, registered one-hot grant suitable for direct one-hot-to-index conversion downstream.

Function
REQ-008 SHALL implement two states: IDLE (grant_valid=0) and GRANTED (grant_valid=1).
REQ-009 SHALL hold an internal priority pointer of max(1, clog2(C_WIDTH)) bits naming the highest-priority requester.
REQ-010 SHALL, in IDLE with any request bit set, select the first set bit at or above the pointer, wrapping from C_WIDTH-1 to 0, and register it into grant with grant_valid=1 on the next edge (1-cycle latency).
REQ-011 SHALL, in IDLE with request all zero, remain in IDLE with grant=0.
REQ-012 SHALL, in GRANTED with grant_ack=0, hold grant and grant_valid unchanged regardless of request changes, including withdrawal of the granted request.
REQ-013 SHALL, in GRANTED with grant_ack=1, set the pointer to (granted index + 1) mod C_WIDTH on that edge.
REQ-014 SHALL, on the same acknowledging edge, arbitrate the current request vector from the updated pointer: any set bit gives a new grant next cycle (back-to-back, one grant per cycle); none returns to IDLE with grant=0.
REQ-015 SHALL, in an acknowledging cycle, still consider the just-acknowledged requester, at lowest priority only.
REQ-016 SHALL ignore grant_ack while grant_valid=0; the pointer is unchanged.
REQ-017 SHALL keep grant onehot0 at all times: exactly one bit set when grant_valid=1, all zero when grant_valid=0.
REQ-018 SHALL, for C_WIDTH=1, keep the pointer constant at 0 and behave as a single request/ack holding register.
REQ-019 SHALL update the pointer only on acknowledgement, never on grant issue.

Reset
REQ-020 SHALL, while rst=0, force grant_valid=0, grant=0, pointer=0, state IDLE asynchronously.
REQ-021 SHALL, when rst asserts mid-grant, discard the outstanding grant with no acknowledgement implied.
REQ-022 SHALL, after rst deasserts, first arbitrate on the next rising edge with requester 0 highest priority.

Verification
REQ-023 SHALL cover reset: C_WIDTH=4, rst=0 with request=4'b1111 -> grant=4'b0000, grant_valid=0 held; first edge after release -> grant=4'b0001.
REQ-024 SHALL cover rotation: request=4'b1111 held, grant_ack=1 every valid cycle -> grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles, grant_valid continuously 1.
REQ-025 SHALL cover hold: grant=4'b0100 issued, request drops to 0, grant_ack=0 for 5 cycles -> grant=4'b0100, grant_valid=1 unchanged throughout.
REQ-026 SHALL cover wrap: ack of grant 4'b0100 (pointer becomes 3) with request=4'b0011 -> next grant=4'b0001.
REQ-027 SHALL cover drain and spurious ack: ack with request=0 -> grant_valid=0 next cycle; grant_ack=1 in IDLE for 3 cycles, then request=4'b0011 -> grant follows the unchanged pointer.
REQ-028 SHALL cover reset mid-operation: rst asserted asynchronously between edges while grant=4'b0010 -> outputs zero before the next edge; after release, request=4'b1010 -> grant=4'b0010 (pointer back to 0).
